// File: rtl/ife_pkg.sv
// Shared types and default widths for the IFE redundant-execution scheduler slice.
package ife_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALLOC,
      START,
      RUN,
      COMMIT,
      ABORT,
      SERIAL
   } sched_state_e;

   localparam int DEF_BLOCK_ID_WIDTH = 8;
   localparam int DEF_NUM_CORES      = 4;
   localparam int DEF_TIMEOUT        = 256;
   localparam int DEF_CNT_WIDTH      = 16;

endpackage

// File: rtl/ife_rr_pair_picker.sv
// Combinational round-robin picker: finds the first two idle cores cyclically from rr_ptr.
module ife_rr_pair_picker #(
   parameter  int NUM_CORES = 4,
   localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic [NUM_CORES-1:0] idle_mask,
   input  logic [IDX_W-1:0]     rr_ptr,
   output logic                 pair_found,
   output logic [IDX_W-1:0]     idx_a,
   output logic [IDX_W-1:0]     idx_b
);

   if (NUM_CORES < 2) begin : g_bad_cores
      $error("ife_rr_pair_picker: NUM_CORES must be >= 2");
   end

   logic [2*NUM_CORES-1:0] rotated;
   logic                   found_a;
   logic                   found_b;
   int                     a_int;
   int                     b_int;

   // Rotating the doubled mask puts rr_ptr at bit 0, so the first two set
   // bits in the low half are A and B in cyclic order.
   always_comb begin
      rotated = {idle_mask, idle_mask} >> rr_ptr;
      found_a = 1'b0;
      found_b = 1'b0;
      a_int   = 0;
      b_int   = 0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (rotated[k]) begin
            if (!found_a) begin
               found_a = 1'b1;
               a_int   = (int'(rr_ptr) + k) % NUM_CORES;
            end else if (!found_b) begin
               found_b = 1'b1;
               b_int   = (int'(rr_ptr) + k) % NUM_CORES;
            end
         end
      end
   end

   assign pair_found = found_a && found_b;
   assign idx_a      = IDX_W'(a_int);
   assign idx_b      = IDX_W'(b_int);

endmodule

// File: rtl/ife_core_scheduler.sv
// Runs one dispatched block on a round-robin pair of cores, then routes it to commit
// or to serial re-execution on mismatch/timeout.
module ife_core_scheduler
   import ife_pkg::*;
#(
   parameter  int BLOCK_ID_WIDTH = DEF_BLOCK_ID_WIDTH,
   parameter  int NUM_CORES      = DEF_NUM_CORES,
   parameter  int TIMEOUT        = DEF_TIMEOUT,
   parameter  int CNT_WIDTH      = DEF_CNT_WIDTH,
   localparam int IDX_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
   localparam int TMR_W          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [BLOCK_ID_WIDTH-1:0] req_block_id,
   input  logic [NUM_CORES-1:0]      core_idle_mask,
   output logic [NUM_CORES-1:0]      core_start,
   output logic [NUM_CORES-1:0]      core_abort,
   output logic [BLOCK_ID_WIDTH-1:0] core_block_id,
   input  logic [NUM_CORES-1:0]      core_done,
   output logic                      commit_valid,
   output logic [BLOCK_ID_WIDTH-1:0] commit_block_id,
   input  logic                      commit_ok,
   input  logic                      commit_fail,
   output logic                      serial_valid,
   output logic [BLOCK_ID_WIDTH-1:0] serial_block_id,
   input  logic                      serial_ready,
   output logic                      busy,
   output logic [CNT_WIDTH-1:0]      cnt_ok,
   output logic [CNT_WIDTH-1:0]      cnt_fail,
   output logic [CNT_WIDTH-1:0]      cnt_timeout
);

   if (NUM_CORES < 2 || TIMEOUT < 2) begin : g_bad_params
      $error("ife_core_scheduler: NUM_CORES and TIMEOUT must both be >= 2");
   end

   localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_CORE  = IDX_W'(NUM_CORES - 1);

   sched_state_e              state;
   logic [IDX_W-1:0]          rr_ptr;
   logic [NUM_CORES-1:0]      pair_mask;
   logic [NUM_CORES-1:0]      done_seen;
   logic [NUM_CORES-1:0]      done_now;
   logic [TMR_W-1:0]          timer;
   logic [BLOCK_ID_WIDTH-1:0] blk_id;
   logic                      ready_q;
   logic                      pair_found;
   logic [IDX_W-1:0]          idx_a;
   logic [IDX_W-1:0]          idx_b;

   ife_rr_pair_picker #(.NUM_CORES(NUM_CORES)) u_picker (
      .idle_mask  (core_idle_mask),
      .rr_ptr     (rr_ptr),
      .pair_found (pair_found),
      .idx_a      (idx_a),
      .idx_b      (idx_b)
   );

   assign done_now = done_seen | (core_done & pair_mask);

   // ready_q is separate from state so req_ready stays low while reset is held
   // and only rises on the first clock after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         pair_mask   <= '0;
         done_seen   <= '0;
         timer       <= '0;
         blk_id      <= '0;
         ready_q     <= 1'b0;
         cnt_ok      <= '0;
         cnt_fail    <= '0;
         cnt_timeout <= '0;
      end else begin
         case (state)
            IDLE: begin
               ready_q <= 1'b1;
               if (req_valid && ready_q) begin
                  blk_id  <= req_block_id;
                  ready_q <= 1'b0;
                  state   <= ALLOC;
               end
            end
            ALLOC: begin
               if (pair_found) begin
                  pair_mask <= (NUM_CORES'(1) << idx_a) | (NUM_CORES'(1) << idx_b);
                  rr_ptr    <= (idx_b == LAST_CORE) ? '0 : idx_b + 1'b1;
                  state     <= START;
               end
            end
            START: begin
               done_seen <= '0;
               timer     <= '0;
               state     <= RUN;
            end
            RUN: begin
               done_seen <= done_now;
               if (done_now == pair_mask) begin
                  state <= COMMIT;
               end else if (timer == TIMER_LAST) begin
                  state <= ABORT;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            COMMIT: begin
               if (commit_fail) begin
                  if (cnt_fail != '1) cnt_fail <= cnt_fail + 1'b1;
                  state <= SERIAL;
               end else if (commit_ok) begin
                  if (cnt_ok != '1) cnt_ok <= cnt_ok + 1'b1;
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            ABORT: begin
               if (cnt_timeout != '1) cnt_timeout <= cnt_timeout + 1'b1;
               state <= SERIAL;
            end
            SERIAL: begin
               if (serial_ready) begin
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready       = ready_q;
   assign busy            = (state != IDLE);
   assign core_start      = (state == START)  ? pair_mask : '0;
   assign core_block_id   = (state == START)  ? blk_id    : '0;
   assign core_abort      = (state == ABORT)  ? pair_mask : '0;
   assign commit_valid    = (state == COMMIT);
   assign commit_block_id = (state == COMMIT) ? blk_id    : '0;
   assign serial_valid    = (state == SERIAL);
   assign serial_block_id = (state == SERIAL) ? blk_id    : '0;

endmodule
